// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, Rcon table, word/block types and the
// key-schedule FSM state encoding.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Entry 0 is never used by the schedule; rounds index 1..10 directly.
  localparam logic [7:0] AES_RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte lane, purely combinational lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per cycle into an 11-entry file read by index.
// Define AES_KEY_EXPAND_DEC_EN to add the reversed-index read port rk_dec_out.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          kld,
  input  logic [KW-1:0] key_in,
  input  logic [3:0]    rk_idx,
  output logic [KW-1:0] rk_out,
  output logic          busy,
  output logic          key_ready,
`ifdef AES_KEY_EXPAND_DEC_EN
  output logic [KW-1:0] rk_dec_out,
`endif
  output logic [1:0]    state_dbg
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  // kld is a one-cycle strobe with no ready: a load is always accepted at the
  // edge it is sampled on, and aborts any expansion already in flight.
  state_t      state;
  logic [3:0]  rnd;
  block_t      key_file [0:NR];

  block_t      prev_key;
  word_t       w0, w1, w2, w3;
  word_t       rot_w3, sub_w3, t;
  word_t       n0, n1, n2, n3;
  logic        idx_ok;

  assign prev_key = key_file[rnd - 4'd1];
  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];
  assign rot_w3 = rot_word(w3);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot_w3[8*b +: 8]),
      .y (sub_w3[8*b +: 8])
    );
  end

  assign t  = sub_w3 ^ {AES_RCON[rnd], 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign idx_ok    = (rk_idx <= NR_IDX);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      busy      <= 1'b0;
      key_ready <= 1'b0;
      rk_out    <= '0;
`ifdef AES_KEY_EXPAND_DEC_EN
      rk_dec_out <= '0;
`endif
      for (int i = 0; i <= NR; i++) key_file[i] <= '0;
    end else begin
      rk_out <= idx_ok ? key_file[rk_idx] : '0;
`ifdef AES_KEY_EXPAND_DEC_EN
      rk_dec_out <= idx_ok ? key_file[NR_IDX - rk_idx] : '0;
`endif
      if (kld) begin
        key_file[0] <= key_in;
        rnd         <= 4'd1;
        state       <= EXPAND;
        busy        <= 1'b1;
        key_ready   <= 1'b0;
      end else begin
        case (state)
          EXPAND: begin
            key_file[rnd] <= {n0, n1, n2, n3};
            if (rnd == NR_IDX) begin
              state     <= READY;
              busy      <= 1'b0;
              key_ready <= 1'b1;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 table, timing/restart/reset
// sequences and random keys against a field-arithmetic key schedule model.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         kld;
  logic [127:0] key_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         busy;
  logic         key_ready;
  logic [1:0]   state_dbg;
`ifdef AES_KEY_EXPAND_DEC_EN
  logic [127:0] rk_dec_out;
`endif

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .kld       (kld),
    .key_in    (key_in),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out),
    .busy      (busy),
    .key_ready (key_ready),
`ifdef AES_KEY_EXPAND_DEC_EN
    .rk_dec_out(rk_dec_out),
`endif
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // ---------------- reference model ----------------
  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [11];
  logic [127:0] model_rk [11];
  logic [127:0] exp_q [$];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_model_tables();
    logic [7:0] inv;
    logic [7:0] rc;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc = 8'h01;
    rcon_m[0] = 8'h00;
    for (int r = 1; r <= 10; r++) begin
      rcon_m[r] = rc;
      rc = gf_mul(rc, 8'h02);
    end
  endtask

  // Classic 44-word formulation of the AES-128 schedule.
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rcon_m[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [127:0] k);
    kld = 1'b1;
    key_in = k;
    tick();
    kld = 1'b0;
    key_in = $urandom();
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!key_ready && cnt < 30) begin
      tick();
      cnt++;
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] v, output logic [127:0] vd);
    rk_idx = idx;
    tick();
    v = rk_out;
`ifdef AES_KEY_EXPAND_DEC_EN
    vd = rk_dec_out;
`else
    vd = 128'h0;
`endif
  endtask

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cnt;
    logic [127:0] v, vd, k;

    build_model_tables();
    rst = 1'b1; kld = 1'b0; key_in = '0; rk_idx = '0;
    tick(); tick();
    check("reset_busy", {127'h0, busy}, 128'h0);
    check("reset_ready", {127'h0, key_ready}, 128'h0);
    check("reset_rk_out", rk_out, 128'h0);

    // rst and kld together: reset wins
    kld = 1'b1; key_in = FIPS_KEY;
    tick();
    kld = 1'b0; rst = 1'b0;
    check("rst_beats_kld", {127'h0, busy}, 128'h0);

    // FIPS-197 table
    vecs[0] = '{"fips_r0",  FIPS_KEY, 4'd0,  FIPS_KEY};
    vecs[1] = '{"fips_r1",  FIPS_KEY, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{"fips_r10", FIPS_KEY, 4'd10, FIPS_R10};
    vecs[3] = '{"zero_r1",  128'h0,   4'd1,  128'h62636363626363636263636362636363};
    vecs[4] = '{"zero_r10", 128'h0,   4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    for (int i = 0; i < 5; i++) begin
      load(vecs[i].key);
      wait_ready(cnt);
      read_rk(vecs[i].idx, v, vd);
      check(vecs[i].name, v, vecs[i].exp);
    end

    // Timing: busy after the load edge, key_ready exactly 10 cycles later
    load(FIPS_KEY);
    check("busy_after_kld", {127'h0, busy}, 128'h1);
    check("ready_low_after_kld", {127'h0, key_ready}, 128'h0);
    wait_ready(cnt);
    check("ready_latency", 128'(cnt), 128'd10);
    check("busy_low_when_ready", {127'h0, busy}, 128'h0);
`ifdef AES_KEY_EXPAND_DEC_EN
    read_rk(4'd0, v, vd);
    check("dec_idx0", vd, FIPS_R10);
    read_rk(4'd10, v, vd);
    check("dec_idx10", vd, FIPS_KEY);
`endif

    // Out-of-range indices return zero
    for (int i = 11; i < 16; i++) begin
      read_rk(4'(i), v, vd);
      check("oor_rk_out", v, 128'h0);
`ifdef AES_KEY_EXPAND_DEC_EN
      check("oor_rk_dec_out", vd, 128'h0);
`endif
    end

    // kld in READY drops key_ready at that edge
    load(128'h00112233445566778899aabbccddeeff);
    check("reload_drops_ready", {127'h0, key_ready}, 128'h0);
    wait_ready(cnt);

    // Restart: key A, then the FIPS key three cycles into expansion
    load({$urandom(), $urandom(), $urandom(), $urandom()});
    tick(); tick(); tick();
    load(FIPS_KEY);
    wait_ready(cnt);
    check("restart_latency", 128'(cnt), 128'd10);
    read_rk(4'd10, v, vd);
    check("restart_r10", v, FIPS_R10);

    // Reset mid-expansion clears everything and nothing completes afterwards
    load(FIPS_KEY);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {127'h0, busy}, 128'h0);
    check("midrst_ready", {127'h0, key_ready}, 128'h0);
    for (int i = 0; i < 16; i++) begin
      read_rk(4'(i), v, vd);
      check("midrst_rk_out", v, 128'h0);
    end
    check("midrst_no_ready", {127'h0, key_ready}, 128'h0);

    // Random keys against the model, all 11 slots via the expected queue
    for (int n = 0; n < 6; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_expand(k);
      load(k);
      wait_ready(cnt);
      check("rand_latency", 128'(cnt), 128'd10);
      for (int r = 0; r < 11; r++) exp_q.push_back(model_rk[r]);
      for (int r = 0; r < 11; r++) begin
        read_rk(4'(r), v, vd);
        check("rand_rk", v, exp_q.pop_front());
`ifdef AES_KEY_EXPAND_DEC_EN
        check("rand_rk_dec", vd, model_rk[10 - r]);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
